// File: rtl/pkt_tx.sv
// pkt_tx: buffered packet transmitter for a switch input port.
// Frames ADDR, PAYLOAD bytes and a PARITY byte, then an inter-packet gap.
module pkt_tx #(
  parameter int DEPTH = 16,
  parameter int IPG   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic [4:0] count,
  input  logic       send,
  input  logic [7:0] send_addr,
  input  logic [4:0] send_len,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       data_status,
  output logic [7:0] data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  localparam logic [3:0] LP_GAP  = 4'((IPG > 0) ? IPG - 1 : 0);
  localparam logic       LP_GBSY = (IPG > 1);
  localparam logic [4:0] LP_DEP  = 5'(DEPTH);

  state_t     r_state;
  logic [7:0] r_mem [0:15];
  logic [3:0] r_wp;
  logic [3:0] r_rp;
  logic [3:0] r_left;
  logic [3:0] r_gap;
  logic [7:0] r_par;

  logic       w_open;
  logic       w_len_ok;
  logic       w_accept;
  logic       w_reject;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [7:0] w_byte;
  logic [4:0] w_cnt_nx;

  // The last gap cycle already behaves as idle so IPG zero cycles separate packets.
  assign w_open   = (r_state == S_IDLE) ||
                    ((r_state == S_GAP) && (r_gap == 4'd0));
  assign w_len_ok = (send_len != 5'd0) && (send_len <= LP_DEP) &&
                    (count >= send_len);
  assign w_accept = w_open && send && w_len_ok;
  assign w_reject = w_open && send && !w_len_ok;
  assign w_pop    = (r_state == S_ADDR) ||
                    ((r_state == S_PAYLOAD) && (r_left != 4'd0));
  assign w_push   = wr_en && (!full || w_pop);
  assign w_drop   = wr_en && full && !w_pop;
  assign w_byte   = r_mem[r_rp];
  assign w_cnt_nx = count + 5'(w_push) - 5'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wp        <= 4'd0;
      r_rp        <= 4'd0;
      r_left      <= 4'd0;
      r_gap       <= 4'd0;
      r_par       <= 8'd0;
      count       <= 5'd0;
      full        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      data_status <= 1'b0;
      data        <= 8'd0;
    end else begin
      done  <= 1'b0;
      err   <= w_reject || w_drop;
      count <= w_cnt_nx;
      full  <= (w_cnt_nx == LP_DEP);
      if (w_push) r_wp <= r_wp + 4'd1;
      if (w_pop)  r_rp <= r_rp + 4'd1;
      unique case (r_state)
        S_IDLE, S_GAP: begin
          data        <= 8'd0;
          data_status <= 1'b0;
          if ((r_state == S_GAP) && (r_gap != 4'd0)) begin
            r_gap <= r_gap - 4'd1;
            busy  <= (r_gap != 4'd1);
          end else if (w_accept) begin
            r_state     <= S_ADDR;
            data        <= send_addr;
            data_status <= 1'b1;
            busy        <= 1'b1;
            r_par       <= send_addr;
            r_left      <= 4'(send_len - 5'd1);
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_ADDR: begin
          r_state     <= S_PAYLOAD;
          data        <= w_byte;
          data_status <= 1'b1;
          r_par       <= r_par ^ w_byte;
        end
        S_PAYLOAD: begin
          if (r_left == 4'd0) begin
            r_state     <= S_PARITY;
            data        <= r_par;
            data_status <= 1'b0;
            done        <= 1'b1;
          end else begin
            data        <= w_byte;
            data_status <= 1'b1;
            r_par       <= r_par ^ w_byte;
            r_left      <= r_left - 4'd1;
          end
        end
        S_PARITY: begin
          data        <= 8'd0;
          data_status <= 1'b0;
          if (IPG == 0) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= S_GAP;
            r_gap   <= LP_GAP;
            busy    <= LP_GBSY;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          data        <= 8'd0;
          data_status <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx.sv
// tb_pkt_tx: scoreboard bench for pkt_tx.
// Stimulus queues expected stream bytes; a negedge monitor checks them.
module tb_pkt_tx;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [4:0] count;
  logic       send;
  logic [7:0] send_addr;
  logic [4:0] send_len;
  logic       busy;
  logic       done;
  logic       err;
  logic       data_status;
  logic [7:0] data;

  typedef struct packed {
    logic       st;
    logic       dn;
    logic [7:0] d;
  } ev_t;

  ev_t        expq[$];
  logic [7:0] mq[$];
  int         checks = 0;
  int         errors = 0;

  pkt_tx #(.DEPTH(16), .IPG(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .count       (count),
    .send        (send),
    .send_addr   (send_addr),
    .send_len    (send_len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .data_status (data_status),
    .data        (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (data_status === 1'b1 || done === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected st=%0b dn=%0b d=%0h at %0t",
                 data_status, done, data, $time);
      end else begin
        ev_t ev;
        ev = expq.pop_front();
        chk("stream", {22'd0, data_status, done, data},
            {22'd0, ev.st, ev.dn, ev.d});
      end
    end else begin
      chk("quiet", {24'd0, data}, 32'd0);
    end
  end

  task automatic expect_pkt(input logic [7:0] a, input logic [4:0] l,
                            output logic ok);
    logic [7:0] par;
    logic [7:0] b;
    ok = (l >= 5'd1) && (l <= 5'd16) && (mq.size() >= int'(l));
    if (ok) begin
      par = a;
      expq.push_back({1'b1, 1'b0, a});
      for (int i = 0; i < int'(l); i++) begin
        b = mq.pop_front();
        par = par ^ b;
        expq.push_back({1'b1, 1'b0, b});
      end
      expq.push_back({1'b0, 1'b1, par});
    end
  endtask

  task automatic push(input logic [7:0] b);
    logic drop;
    drop = (mq.size() >= 16);
    if (!drop) mq.push_back(b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    chk("push_err", {31'd0, err}, {31'd0, drop});
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [4:0] l);
    logic ok;
    expect_pkt(a, l, ok);
    send = 1'b1;
    send_addr = a;
    send_len = l;
    @(negedge clk);
    send = 1'b0;
    chk("send_err", {31'd0, err}, {31'd0, !ok});
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 60) begin
      errors++;
      $display("FAIL done_timeout got 0 want 1 at %0t", $time);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle", {31'd0, busy}, 32'd0);
    chk("drained", expq.size(), 32'd0);
    chk("count", {27'd0, count}, mq.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int zeros;
    logic ok;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'd0;
    send = 1'b0;
    send_addr = 8'd0;
    send_len = 5'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_flags", {27'd0, full, busy, done, err, data_status}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("cnt3", {27'd0, count}, 32'd3);
    send_pkt(8'h05, 5'd3);
    wait_done();
    @(negedge clk);
    chk("busy_gap", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("cnt0", {27'd0, count}, 32'd0);

    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    chk("full16", {26'd0, full, count}, {26'd0, 1'b1, 5'd16});
    push(8'hEE);
    chk("drop16", {26'd0, full, count}, {26'd0, 1'b1, 5'd16});
    send_pkt(8'h3C, 5'd16);
    wait_idle();
    chk("empty", {26'd0, full, count}, 32'd0);

    push(8'h5A);
    push(8'hA5);
    send_pkt(8'h77, 5'd3);
    @(negedge clk);
    chk("err_pulse", {31'd0, err}, 32'd0);
    send_pkt(8'h77, 5'd0);
    send_pkt(8'h77, 5'd17);
    chk("rej_state", {26'd0, busy, count}, {26'd0, 1'b0, 5'd2});

    for (int i = 0; i < 12; i++) push(8'hC0 + 8'(i));
    chk("cnt14", {27'd0, count}, 32'd14);
    send_pkt(8'h81, 5'd6);
    wait_done();
    expect_pkt(8'h82, 5'd8, ok);
    send = 1'b1;
    send_addr = 8'h82;
    send_len = 5'd8;
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_status) break;
      zeros++;
    end
    send = 1'b0;
    chk("gap_len", zeros, 32'd2);
    chk("b2b_ok", {31'd0, ok}, 32'd1);
    wait_idle();

    push(8'hD1);
    push(8'hD2);
    push(8'hD3);
    push(8'hD4);
    send_pkt(8'h99, 5'd4);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    expq.delete();
    mq.delete();
    #1;
    chk("abort_st", {31'd0, data_status}, 32'd0);
    chk("abort_d", {24'd0, data}, 32'd0);
    chk("abort_cnt", {26'd0, busy, count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push(8'hE1);
    push(8'hE2);
    send_pkt(8'h42, 5'd2);
    wait_idle();

    for (int i = 0; i < 16; i++) push(8'hF0 + 8'(i));
    send_pkt(8'h10, 5'd4);
    wr_en = 1'b1;
    wr_data = 8'h5C;
    mq.push_back(8'h5C);
    @(negedge clk);
    chk("fpush1", {31'd0, err}, 32'd0);
    wr_data = 8'hC5;
    mq.push_back(8'hC5);
    @(negedge clk);
    wr_en = 1'b0;
    chk("fpush2", {31'd0, err}, 32'd0);
    chk("fcount", {26'd0, full, count}, {26'd0, 1'b1, 5'd16});
    wait_idle();
    chk("cnt14b", {27'd0, count}, 32'd14);
    send_pkt(8'h20, 5'd14);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
